// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 8-bit CPU.
// Owns the program counter and instruction register, and steps every
// instruction through FETCH -> EXEC (-> MEM) phases, stopping in DONE on
// HALT or on a data-memory timeout.
module cpu_sequencer #(
    parameter int PCW         = 8,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNTW        = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [7:0]      instruction,
    input  logic            lt_flag,
    input  logic            ne_flag,
    input  logic            mem_ready,
    output logic [PCW-1:0]  pc,
    output logic [7:0]      ir,
    output logic            reg_we,
    output logic            flag_we,
    output logic            mem_req,
    output logic            mem_we,
    output logic            Ack,
    output logic            err,
    output logic [CNTW-1:0] cycle_count
);

    // The wait counter only ever has to hold 0 .. MEM_TIMEOUT-1.
    localparam int WAITW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CL_R    = 4'd0,
        CL_HALT = 4'd1,
        CL_CMP  = 4'd2,
        CL_IMME = 4'd3,
        CL_BLT  = 4'd4,
        CL_BNE  = 4'd5,
        CL_LW   = 4'd6,
        CL_SW   = 4'd7,
        CL_ALW  = 4'd8,
        CL_ASW  = 4'd9
    } op_class_t;

    // Opcode classifier; the order of the tests is the match priority
    // (HALT must be tested before the wider CMP pattern).
    function automatic op_class_t decode_class(input logic [7:0] op);
        op_class_t cls;
        if (op == 8'b0111_0000) begin
            cls = CL_HALT;
        end else if (op[7:3] == 5'b01110) begin
            cls = CL_CMP;
        end else if (op[7:6] == 2'b10) begin
            cls = CL_IMME;
        end else if (op[7:5] == 3'b110) begin
            cls = CL_BLT;
        end else if (op[7:5] == 3'b111) begin
            cls = CL_BNE;
        end else if (op[7:3] == 5'b01101) begin
            cls = CL_LW;
        end else if (op[7:3] == 5'b01100) begin
            cls = CL_SW;
        end else if (op[7:1] == 7'b0111110) begin
            cls = CL_ALW;
        end else if (op[7:1] == 7'b0111111) begin
            cls = CL_ASW;
        end else begin
            cls = CL_R;
        end
        return cls;
    endfunction

    state_t          state_r, state_nxt_s;
    logic [PCW-1:0]  pc_r, pc_nxt_s;
    logic [7:0]      ir_r, ir_nxt_s;
    logic            ack_r, ack_nxt_s;
    logic            err_r, err_nxt_s;
    logic [CNTW-1:0] cnt_r, cnt_nxt_s;
    logic [WAITW-1:0] wait_r, wait_nxt_s;

    op_class_t       op_cls_s;
    logic            is_load_s;
    logic            is_store_s;
    logic [PCW-1:0]  pc_inc_s;
    logic [PCW-1:0]  pc_br_s;
    logic [CNTW-1:0] cnt_inc_s;

    assign op_cls_s   = decode_class(ir_r);
    assign is_load_s  = (op_cls_s == CL_LW) || (op_cls_s == CL_ALW);
    assign is_store_s = (op_cls_s == CL_SW) || (op_cls_s == CL_ASW);
    assign pc_inc_s   = pc_r + PCW'(1);
    // Sign-extended 5-bit branch offset; the adder wraps modulo 2**PCW.
    assign pc_br_s    = pc_r + {{(PCW-5){ir_r[4]}}, ir_r[4:0]};
    // Saturating cycle counter increment.
    assign cnt_inc_s  = (cnt_r == {CNTW{1'b1}}) ? cnt_r : (cnt_r + CNTW'(1));

    // Next-state, next-register and strobe decode for the sequencer.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        ir_nxt_s    = ir_r;
        ack_nxt_s   = ack_r;
        err_nxt_s   = err_r;
        cnt_nxt_s   = cnt_r;
        wait_nxt_s  = wait_r;
        reg_we      = 1'b0;
        flag_we     = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_nxt_s = ST_FETCH;
                    pc_nxt_s    = '0;
                    cnt_nxt_s   = '0;
                    ack_nxt_s   = 1'b0;
                    err_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = state_r;
                end
            end

            ST_FETCH: begin
                cnt_nxt_s   = cnt_inc_s;
                ir_nxt_s    = instruction;
                state_nxt_s = ST_EXEC;
            end

            ST_EXEC: begin
                cnt_nxt_s = cnt_inc_s;
                case (op_cls_s)
                    CL_HALT: begin
                        ack_nxt_s   = 1'b1;
                        state_nxt_s = ST_DONE;
                    end
                    CL_CMP: begin
                        flag_we     = 1'b1;
                        pc_nxt_s    = pc_inc_s;
                        state_nxt_s = ST_FETCH;
                    end
                    CL_BLT: begin
                        pc_nxt_s    = lt_flag ? pc_br_s : pc_inc_s;
                        state_nxt_s = ST_FETCH;
                    end
                    CL_BNE: begin
                        pc_nxt_s    = ne_flag ? pc_br_s : pc_inc_s;
                        state_nxt_s = ST_FETCH;
                    end
                    CL_LW, CL_SW, CL_ALW, CL_ASW: begin
                        wait_nxt_s  = '0;
                        state_nxt_s = ST_MEM;
                    end
                    CL_R, CL_IMME: begin
                        reg_we      = 1'b1;
                        pc_nxt_s    = pc_inc_s;
                        state_nxt_s = ST_FETCH;
                    end
                    default: begin
                        reg_we      = 1'b1;
                        pc_nxt_s    = pc_inc_s;
                        state_nxt_s = ST_FETCH;
                    end
                endcase
            end

            ST_MEM: begin
                cnt_nxt_s = cnt_inc_s;
                mem_req   = 1'b1;
                mem_we    = is_store_s;
                if (mem_ready) begin
                    reg_we      = is_load_s;
                    pc_nxt_s    = pc_inc_s;
                    state_nxt_s = ST_FETCH;
                end else if (wait_r == WAIT_LAST) begin
                    // Memory never answered: abort the program with an error.
                    ack_nxt_s   = 1'b1;
                    err_nxt_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    wait_nxt_s  = wait_r + WAITW'(1);
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            pc_r    <= '0;
            ir_r    <= 8'h00;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            cnt_r   <= '0;
            wait_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            ir_r    <= ir_nxt_s;
            ack_r   <= ack_nxt_s;
            err_r   <= err_nxt_s;
            cnt_r   <= cnt_nxt_s;
            wait_r  <= wait_nxt_s;
        end
    end

    assign pc          = pc_r;
    assign ir          = ir_r;
    assign Ack         = ack_r;
    assign err         = err_r;
    assign cycle_count = cnt_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed programs in a model ROM,
// an instruction-level reference model that expands each instruction into
// its expected per-cycle outputs, and literal checks pinning key results.
module tb_cpu_sequencer;

    localparam int MEM_TIMEOUT = 15;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [7:0]  instruction;
    logic        lt_flag;
    logic        ne_flag;
    logic        mem_ready;
    logic [7:0]  pc;
    logic [7:0]  ir;
    logic        reg_we;
    logic        flag_we;
    logic        mem_req;
    logic        mem_we;
    logic        Ack;
    logic        err;
    logic [15:0] cycle_count;

    logic [7:0]  rom [256];

    cpu_sequencer #(.PCW(8), .MEM_TIMEOUT(MEM_TIMEOUT), .CNTW(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .instruction(instruction),
        .lt_flag(lt_flag), .ne_flag(ne_flag), .mem_ready(mem_ready),
        .pc(pc), .ir(ir), .reg_we(reg_we), .flag_we(flag_we),
        .mem_req(mem_req), .mem_we(mem_we), .Ack(Ack), .err(err),
        .cycle_count(cycle_count)
    );

    always #5 Clk = ~Clk;

    assign instruction = rom[pc];

    // Expected outputs for one clock cycle.
    typedef struct {
        int  pc;
        int  ir;
        bit  chk_ir;
        bit  reg_we, flag_we, mem_req, mem_we, ack, err;
        int  cnt;
        bit  is_done;
    } rec_t;

    rec_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state (instruction level).
    int   m_pc, m_n, mem_lat;
    bit   m_done, m_err;
    bit   model_on = 1'b0;
    bit   done_seen;
    int   obs_mreq, obs_mwe, obs_rwe, obs_fwe;
    int   mreq_run = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int p, input int op, input bit ci, input bit rw, input bit fw,
                        input bit mr, input bit mw, input bit ak, input bit er, input bit dn);
        rec_t r;
        r.pc = p; r.ir = op; r.chk_ir = ci;
        r.reg_we = rw; r.flag_we = fw; r.mem_req = mr; r.mem_we = mw;
        r.ack = ak; r.err = er; r.is_done = dn;
        r.cnt = (m_n > 65535) ? 65535 : m_n;
        if (!dn) m_n++;
        exp_q.push_back(r);
    endtask

    // Expand the instruction at m_pc into the cycles it must take.
    task automatic gen_next();
        logic [7:0] op;
        int off;
        bit taken, ld, st;
        if (m_done) begin
            push(m_pc, 0, 1'b0, 0, 0, 0, 0, 1'b1, m_err, 1'b1);
        end else begin
            op = rom[m_pc];
            push(m_pc, 0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
            off = int'(op[4:0]);
            if (off > 15) off -= 32;
            ld = 1'b0; st = 1'b0;
            casez (op)
                8'b0111_0000: begin
                    push(m_pc, op, 1'b1, 0, 0, 0, 0, 0, 0, 1'b0);
                    m_done = 1'b1;
                end
                8'b0111_0???: begin
                    push(m_pc, op, 1'b1, 0, 1, 0, 0, 0, 0, 1'b0);
                    m_pc = (m_pc + 1) % 256;
                end
                8'b10??_????: begin
                    push(m_pc, op, 1'b1, 1, 0, 0, 0, 0, 0, 1'b0);
                    m_pc = (m_pc + 1) % 256;
                end
                8'b11??_????: begin
                    taken = op[5] ? ne_flag : lt_flag;
                    push(m_pc, op, 1'b1, 0, 0, 0, 0, 0, 0, 1'b0);
                    m_pc = (m_pc + (taken ? off : 1) + 256) % 256;
                end
                8'b0110_1???, 8'b0111_110?: ld = 1'b1;
                8'b0110_0???, 8'b0111_111?: st = 1'b1;
                default: begin
                    push(m_pc, op, 1'b1, 1, 0, 0, 0, 0, 0, 1'b0);
                    m_pc = (m_pc + 1) % 256;
                end
            endcase
            if (ld || st) begin
                push(m_pc, op, 1'b1, 0, 0, 0, 0, 0, 0, 1'b0);
                if (mem_lat < MEM_TIMEOUT) begin
                    for (int k = 0; k < mem_lat; k++)
                        push(m_pc, op, 1'b1, 0, 0, 1, st, 0, 0, 1'b0);
                    push(m_pc, op, 1'b1, ld, 0, 1, st, 0, 0, 1'b0);
                    m_pc = (m_pc + 1) % 256;
                end else begin
                    for (int k = 0; k < MEM_TIMEOUT; k++)
                        push(m_pc, op, 1'b1, 0, 0, 1, st, 0, 0, 1'b0);
                    m_done = 1'b1;
                    m_err  = 1'b1;
                end
            end
        end
    endtask

    // Data-memory responder: answers mem_lat cycles after a request opens.
    always begin
        @(negedge Clk);
        if (mem_req) begin
            mem_ready = (mreq_run == mem_lat);
            mreq_run++;
        end else begin
            mem_ready = 1'b0;
            mreq_run  = 0;
        end
    end

    // Compare DUT outputs against the model every running cycle.
    always begin
        rec_t cur;
        @(negedge Clk);
        #1;
        if (model_on) begin
            if (exp_q.size() == 0) gen_next();
            cur = exp_q.pop_front();
            chk("pc", {24'h0, pc}, cur.pc);
            if (cur.chk_ir) chk("ir", {24'h0, ir}, cur.ir);
            chk("reg_we", {31'h0, reg_we}, {31'h0, cur.reg_we});
            chk("flag_we", {31'h0, flag_we}, {31'h0, cur.flag_we});
            chk("mem_req", {31'h0, mem_req}, {31'h0, cur.mem_req});
            chk("mem_we", {31'h0, mem_we}, {31'h0, cur.mem_we});
            chk("Ack", {31'h0, Ack}, {31'h0, cur.ack});
            chk("err", {31'h0, err}, {31'h0, cur.err});
            chk("cycle_count", {16'h0, cycle_count}, cur.cnt);
            if (mem_req) obs_mreq++;
            if (mem_we)  obs_mwe++;
            if (reg_we)  obs_rwe++;
            if (flag_we) obs_fwe++;
            if (cur.is_done) done_seen = 1'b1;
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic start_prog();
        exp_q.delete();
        m_pc = 0; m_n = 0; m_done = 1'b0; m_err = 1'b0; done_seen = 1'b0;
        obs_mreq = 0; obs_mwe = 0; obs_rwe = 0; obs_fwe = 0;
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        model_on = 1'b1;
    endtask

    task automatic wait_done(input string nm, input int bound);
        for (int i = 0; i < bound && !done_seen; i++) @(negedge Clk);
        if (!done_seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: DONE not reached within %0d cycles", nm, bound);
        end
        model_on = 1'b0;
        #1;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; lt_flag = 1'b0; ne_flag = 1'b0;
        mem_ready = 1'b0; mem_lat = 0;
        clear_rom();
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_pc", {24'h0, pc}, 32'h0);
        chk("rst_ir", {24'h0, ir}, 32'h0);
        chk("rst_ack", {31'h0, Ack}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_cnt", {16'h0, cycle_count}, 32'h0);
        chk("rst_strobes", {28'h0, reg_we, flag_we, mem_req, mem_we}, 32'h0);
        Reset = 1'b0;

        // IMME then HALT.
        rom[0] = 8'h81; rom[1] = 8'h70;
        start_prog();
        wait_done("imme_halt", 20);
        chk("t1_cnt", {16'h0, cycle_count}, 32'd4);
        chk("t1_pc", {24'h0, pc}, 32'd1);
        chk("t1_ack", {31'h0, Ack}, 32'd1);
        chk("t1_rwe", obs_rwe, 32'd1);

        // CMP then taken BLT -2.
        clear_rom();
        rom[0] = 8'hC3; rom[2] = 8'h70; rom[3] = 8'h71; rom[4] = 8'hDE;
        lt_flag = 1'b1;
        start_prog();
        wait_done("blt_taken", 40);
        chk("blt_t_pc", {24'h0, pc}, 32'd2);
        chk("blt_t_cnt", {16'h0, cycle_count}, 32'd8);
        chk("blt_t_fwe", obs_fwe, 32'd1);

        // CMP then not-taken BLT.
        clear_rom();
        rom[3] = 8'h71; rom[4] = 8'hDE; rom[5] = 8'h70;
        lt_flag = 1'b0;
        start_prog();
        wait_done("blt_not", 40);
        chk("blt_n_pc", {24'h0, pc}, 32'd5);
        chk("blt_n_cnt", {16'h0, cycle_count}, 32'd12);

        // Chain of BNE +15 hops up to pc 250, then +15 wraps to 9.
        clear_rom();
        for (int a = 0; a <= 225; a += 15) rom[a] = 8'hEF;
        rom[240] = 8'hEA; rom[250] = 8'hEF; rom[9] = 8'h70;
        ne_flag = 1'b1;
        start_prog();
        wait_done("bne_wrap", 100);
        chk("bne_pc", {24'h0, pc}, 32'd9);
        chk("bne_cnt", {16'h0, cycle_count}, 32'd38);
        ne_flag = 1'b0;

        // LW with three wait cycles.
        clear_rom();
        rom[0] = 8'h68; rom[1] = 8'h70;
        mem_lat = 3;
        start_prog();
        wait_done("lw", 40);
        chk("lw_mreq", obs_mreq, 32'd4);
        chk("lw_mwe", obs_mwe, 32'd0);
        chk("lw_rwe", obs_rwe, 32'd1);
        chk("lw_cnt", {16'h0, cycle_count}, 32'd8);

        // SW answered immediately.
        rom[0] = 8'h60;
        mem_lat = 0;
        start_prog();
        wait_done("sw", 40);
        chk("sw_mreq", obs_mreq, 32'd1);
        chk("sw_mwe", obs_mwe, 32'd1);
        chk("sw_rwe", obs_rwe, 32'd0);
        chk("sw_cnt", {16'h0, cycle_count}, 32'd5);

        // ASW never answered: timeout abort.
        rom[0] = 8'h7E;
        mem_lat = 99;
        start_prog();
        wait_done("asw_to", 60);
        chk("to_err", {31'h0, err}, 32'd1);
        chk("to_ack", {31'h0, Ack}, 32'd1);
        chk("to_mreq", obs_mreq, 32'd15);
        chk("to_cnt", {16'h0, cycle_count}, 32'd17);
        chk("to_pc", {24'h0, pc}, 32'd0);

        // Restart from the error DONE.
        rom[0] = 8'h70;
        mem_lat = 0;
        start_prog();
        #1;
        chk("rs_ack", {31'h0, Ack}, 32'd0);
        chk("rs_err", {31'h0, err}, 32'd0);
        chk("rs_pc", {24'h0, pc}, 32'd0);
        wait_done("restart", 20);
        chk("rs_cnt", {16'h0, cycle_count}, 32'd2);

        // Start pulsed during EXEC is ignored.
        rom[0] = 8'h81; rom[1] = 8'h70;
        start_prog();
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_done("start_exec", 20);
        chk("se_cnt", {16'h0, cycle_count}, 32'd4);
        chk("se_pc", {24'h0, pc}, 32'd1);

        // Reset during a MEM wait.
        rom[0] = 8'h68;
        mem_lat = 99;
        start_prog();
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        model_on = 1'b0;
        @(negedge Clk);
        #1;
        chk("mr_mreq", {31'h0, mem_req}, 32'd0);
        chk("mr_pc", {24'h0, pc}, 32'd0);
        chk("mr_ack", {31'h0, Ack}, 32'd0);
        chk("mr_cnt", {16'h0, cycle_count}, 32'd0);
        chk("mr_ir", {24'h0, ir}, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        #1;
        chk("mr_idle_mreq", {31'h0, mem_req}, 32'd0);
        chk("mr_idle_cnt", {16'h0, cycle_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control FSM for the 8-bit CPU. It owns the PC and the instruction register, and it sequences fetch, execute and data-memory phases for every opcode class the decoder recognises. It resolves BLT/BNE using the ALU flags and waits on the data-memory handshake. It also stops on HALT, raising Ack back to the top-level harness.

Parameters:
PCW, 8, PC width; instruction ROM depth is 2**PCW
MEM_TIMEOUT, 15, maximum mem_ready wait cycles before the error abort
CNTW, 16, width of cycle_count

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
Start  in  1  begin execution at PC 0 (sampled in IDLE/DONE only)
instruction  in  8  instruction ROM data at address pc (combinational ROM)
lt_flag  in  1  registered less-than flag from the last CMP
ne_flag  in  1  registered not-equal flag from the last CMP
mem_ready  in  1  data memory completes the current request this cycle
pc  out  PCW  program counter / ROM address
ir  out  8  latched instruction, fed to decoder
reg_we  out  1  register-file write enable
flag_we  out  1  ALU flag register load
mem_req  out  1  data memory request
mem_we  out  1  data memory write (valid only with mem_req)
Ack  out  1  program finished (HALT or error)
err  out  1  memory timeout abort
cycle_count  out  CNTW  cycles spent executing

Behaviour:
- Reset (synchronous, priority over everything): state=IDLE, pc=0, ir=0, Ack=0, err=0, cycle_count=0. The combinational strobes (reg_we, flag_we, mem_req, mem_we) are 0 in IDLE.
- Opcode classes decoded from ir, first match wins:
  - HALT 01110000
  - CMP 01110???
  - IMME 10??????
  - BLT 110?????
  - BNE 111?????
  - LW 01101???
  - SW 01100???
  - ALW 0111110?
  - ASW 0111111?
  - everything else is R-type.
- States: IDLE, FETCH, EXEC, MEM, DONE.
- IDLE: Start=1 -> FETCH; pc=0, cycle_count=0, Ack=0, err=0.
- FETCH: ir <= instruction; -> EXEC. Exactly one cycle.
- EXEC, one cycle, actions by class:
  - R-type/IMME: reg_we=1; pc<=pc+1; -> FETCH.
  - CMP: flag_we=1; pc<=pc+1; -> FETCH.
  - BLT: if lt_flag, pc<=pc+sext(ir[4:0]), otherwise pc+1; -> FETCH.
  - BNE: same as BLT, using ne_flag.
  - LW/ALW/SW/ASW: -> MEM.
  - HALT: pc unchanged; -> DONE.
- Branch offset range is -16..+15. Offset 0 means self-loop and is legal. All pc arithmetic is modulo 2**PCW (wraps both directions).
- Flags are sampled in the EXEC cycle. A CMP immediately before a branch is visible, because flag_we lands at the end of the CMP EXEC cycle.
- MEM:
  - mem_req=1 every cycle in MEM; mem_we=1 for SW/ASW.
  - Wait counter is cleared on MEM entry and increments each cycle mem_ready=0.
  - On mem_ready=1: for LW/ALW, reg_we=1 in that same cycle; pc<=pc+1; -> FETCH.
  - Minimum load/store latency is 3 cycles (FETCH, EXEC, MEM with mem_ready=1).
  - If the wait counter reaches MEM_TIMEOUT with mem_ready still 0: -> DONE, err<=1, mem_req drops next cycle.
- DONE: Ack=1 held, err holds its value. Start=1 -> FETCH with pc=0, Ack<=0, err<=0, cycle_count<=0.
- Start is ignored in FETCH/EXEC/MEM.
- cycle_count increments on every cycle in FETCH/EXEC/MEM, saturates at all-ones, and holds in IDLE/DONE.
- Output timing: reg_we, flag_we, mem_req and mem_we are combinational from state+ir(+mem_ready). pc, ir, Ack, err and cycle_count are registered.
- Reset asserted mid-MEM: all outputs clear on that edge. A pending memory request is abandoned; the memory side must tolerate mem_req dropping.

Test Plan:
- ROM {0x81 IMME, 0x70 HALT}; Reset, then pulse Start -> reg_we high in cycle 2 only, pc 0->1, DONE in cycle 4, Ack=1, cycle_count=4, pc stays 1.
- CMP 0x71 at pc 3 with lt_flag=1, then BLT 0xDE (offset -2) at pc 4 -> flag_we pulse, pc goes 3->4->2. Repeat with lt_flag=0 -> pc 4->5.
- BNE 0xEF (offset +15) at pc 250, PCW=8, ne_flag=1 -> pc wraps to 9.
- LW 0x68 with mem_ready asserted after 3 wait cycles -> mem_req high 4 cycles, mem_we=0, reg_we only in the mem_ready cycle. SW 0x60 with immediate mem_ready -> one cycle of mem_req=mem_we=1.
- ASW 0x7E with mem_ready held 0 -> after 15 wait cycles: DONE, err=1, Ack=1. Then Start -> pc=0, err=0, Ack=0.
- Reset asserted during a MEM wait -> next edge: IDLE, mem_req=0, pc=0. Start pulsed in EXEC -> ignored, flow unchanged.
